change_dispenser: RTL and testbench

Sequences the return of change after a vend or cancel. It takes a credit amount from the FSM controller and drives a coin-ejector handshake, one coin at a time, using a greedy 5/2/1 algorithm. It also tracks how many coins are left in each change tube. It sits between the FSM controller (`change_due`, `change_returning`) and the physical ejector, and shares the coin handler's deposit stream to refill the tubes.

---
 rtl/change_dispenser.sv | 159 +++++++++++++++
 tb/tb_change_dispenser.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy 5/2/1 change dispenser with per-tube coin accounting and an ejector handshake.
// Optional ack timeout: define CHANGE_DISP_TIMEOUT_EN to enable it (fault stays 0 otherwise).
module change_dispenser #(
  parameter int TUBE_INIT   = 8,
  parameter int TUBE_MAX    = 15,
  parameter int GAP_CYCLES  = 25000,
  parameter int ACK_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  amount,
  input  logic        coin_pulse,
  input  logic [7:0]  coin_value,
  input  logic        restock,
  input  logic        eject_ack,
  output logic [2:0]  eject_req,
  output logic        busy,
  output logic        done,
  output logic [7:0]  shortfall,
  output logic        fault,
  output logic [11:0] tube_levels
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0] T_INIT = 4'(TUBE_INIT);
  localparam logic [3:0] T_MAX  = 4'(TUBE_MAX);
`ifdef CHANGE_DISP_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

  state_t           state;
  logic [7:0]       remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       cnt5, cnt2, cnt1;
  logic             ack_take, ack_expire;
  logic [2:0]       dec_vec, clr_vec, dep_vec;

  function automatic logic [7:0] denom(input logic [2:0] req);
    case (req)
      3'b100:  return 8'd5;
      3'b010:  return 8'd2;
      3'b001:  return 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  // Restock beats everything; a deposit and a dispense on the same tube cancel out.
  function automatic logic [3:0] tube_next(input logic [3:0] cnt, input logic dep,
                                           input logic dec, input logic clr, input logic fill);
    if (fill)       return T_MAX;
    if (clr)        return 4'd0;
    if (dep && dec) return cnt;
    if (dec)        return (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    if (dep)        return (cnt >= T_MAX) ? T_MAX : cnt + 4'd1;
    return cnt;
  endfunction

  always_comb begin
    ack_take   = (state == EJECT) && eject_ack;
    ack_expire = TO_EN && (state == EJECT) && !eject_ack && (to_cnt == TO_LAST);
    dec_vec    = ack_take ? eject_req : 3'b000;
    clr_vec    = ack_expire ? eject_req : 3'b000;
    dep_vec    = {coin_pulse && (coin_value == 8'd5),
                  coin_pulse && (coin_value == 8'd2),
                  coin_pulse && (coin_value == 8'd1)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= 8'd0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      eject_req <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      shortfall <= 8'd0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= amount;
            shortfall <= 8'd0;
            fault     <= 1'b0;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          to_cnt <= '0;
          if (remaining >= 8'd5 && cnt5 != 4'd0) begin
            eject_req <= 3'b100;
            state     <= EJECT;
          end else if (remaining >= 8'd2 && cnt2 != 4'd0) begin
            eject_req <= 3'b010;
            state     <= EJECT;
          end else if (remaining >= 8'd1 && cnt1 != 4'd0) begin
            eject_req <= 3'b001;
            state     <= EJECT;
          end else begin
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= FINISH;
          end
        end
        EJECT: begin
          if (ack_take) begin
            eject_req <= 3'b000;
            remaining <= remaining - denom(eject_req);
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (ack_expire) begin
            // Tube is presumed jammed: retry the same remainder with smaller coins.
            eject_req <= 3'b000;
            fault     <= 1'b1;
            state     <= SELECT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
          else if (!eject_ack)     state   <= SELECT;
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt5 <= T_INIT;
      cnt2 <= T_INIT;
      cnt1 <= T_INIT;
    end else begin
      cnt5 <= tube_next(cnt5, dep_vec[2], dec_vec[2], clr_vec[2], restock);
      cnt2 <= tube_next(cnt2, dep_vec[1], dec_vec[1], clr_vec[1], restock);
      cnt1 <= tube_next(cnt1, dep_vec[0], dec_vec[0], clr_vec[0], restock);
    end
  end

  assign tube_levels = {cnt5, cnt2, cnt1};

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser: greedy sequencing, tube accounting, reset, timeout.
module tb_change_dispenser;

  localparam int GAP = 3;
  localparam int ATO = 20;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  amount;
  logic        coin_pulse;
  logic [7:0]  coin_value;
  logic        restock;
  logic        eject_ack;
  logic [2:0]  eject_req;
  logic        busy;
  logic        done;
  logic [7:0]  shortfall;
  logic        fault;
  logic [11:0] tube_levels;

  logic        auto_ack;
  logic        auto_r;
  logic        man_ack;
  logic [2:0]  log_mem [256];
  int          nlog;
  int          checks;
  int          errors;

  assign eject_ack = auto_ack ? auto_r : man_ack;

  change_dispenser #(
    .TUBE_INIT(8), .TUBE_MAX(15), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ATO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .coin_pulse(coin_pulse), .coin_value(coin_value), .restock(restock),
    .eject_ack(eject_ack), .eject_req(eject_req), .busy(busy), .done(done),
    .shortfall(shortfall), .fault(fault), .tube_levels(tube_levels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Automatic ejector: acks each request one half-cycle after it appears, logs it.
  initial begin : responder
    auto_r = 1'b0;
    nlog   = 0;
    forever begin
      @(negedge clk);
      if (auto_ack && eject_req != 3'b000 && !auto_r) begin
        auto_r = 1'b1;
        log_mem[nlog & 255] = eject_req;
        nlog++;
      end else if (eject_req == 3'b000) begin
        auto_r = 1'b0;
      end
    end
  end

  function automatic logic [47:0] pack_log(input int base, input int n);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < n && i < 16; i++) v[3*i +: 3] = log_mem[(base + i) & 255];
    return v;
  endfunction

  task automatic do_start(input logic [7:0] a);
    @(negedge clk);
    start = 1'b1;
    amount = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_coin(input logic [7:0] v);
    @(negedge clk);
    coin_pulse = 1'b1;
    coin_value = v;
    @(negedge clk);
    coin_pulse = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output logic [7:0] sf);
    ok = 1'b0;
    sf = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        sf = shortfall;
        break;
      end
    end
  endtask

  task automatic wait_req(output bit ok, output logic [2:0] r);
    ok = 1'b0;
    r = 3'b000;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (eject_req != 3'b000) begin
        ok = 1'b1;
        r = eject_req;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (eject_req !== 3'b000) begin errors++; $display("FAIL reset_eject_req got=%b exp=000", eject_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (shortfall !== 8'd0) begin errors++; $display("FAIL reset_shortfall got=%0d exp=0", shortfall); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (tube_levels !== 12'h888) begin errors++; $display("FAIL reset_tubes got=%h exp=888", tube_levels); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int base;
    bit ok;
    logic [7:0] sf;
    base = nlog;
    @(negedge clk);
    start = 1'b1;
    amount = 8'd8;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || eject_req !== 3'b000) begin errors++; $display("FAIL basic_lat1 busy=%b req=%b exp busy=1 req=000", busy, eject_req); end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (eject_req !== 3'b100) begin errors++; $display("FAIL basic_lat2 got=%b exp=100", eject_req); end
    wait_done(ok, sf);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done got=timeout exp=done"); end
    checks++; if (sf !== 8'd0) begin errors++; $display("FAIL basic_shortfall got=%0d exp=0", sf); end
    checks++; if (nlog - base != 3 || pack_log(base, 3) !== {39'b0, 3'b001, 3'b010, 3'b100})
      begin errors++; $display("FAIL basic_seq got n=%0d log=%h exp n=3 log=54", nlog - base, pack_log(base, 3)); end
    checks++; if (tube_levels !== 12'h777) begin errors++; $display("FAIL basic_tubes got=%h exp=777", tube_levels); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_deposit;
    int base;
    bit ok;
    logic [7:0] sf;
    base = nlog;
    do_start(8'd30);
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd0) begin errors++; $display("FAIL drain5 ok=%b sf=%0d exp ok=1 sf=0", ok, sf); end
    checks++; if (nlog - base != 6 || pack_log(base, 6) !== {30'b0, {6{3'b100}}})
      begin errors++; $display("FAIL drain5_seq got n=%0d log=%h exp n=6 all 5s", nlog - base, pack_log(base, 6)); end
    checks++; if (tube_levels !== 12'h177) begin errors++; $display("FAIL drain5_tubes got=%h exp=177", tube_levels); end
    pulse_coin(8'd2);
    pulse_coin(8'd3);
    pulse_coin(8'd1);
    checks++; if (tube_levels !== 12'h188) begin errors++; $display("FAIL deposit_tubes got=%h exp=188", tube_levels); end
  endtask

  task automatic test_greedy;
    int base;
    bit ok;
    logic [7:0] sf;
    base = nlog;
    do_start(8'd13);
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd0) begin errors++; $display("FAIL greedy13 ok=%b sf=%0d exp ok=1 sf=0", ok, sf); end
    checks++; if (nlog - base != 5 || pack_log(base, 5) !== {33'b0, {4{3'b010}}, 3'b100})
      begin errors++; $display("FAIL greedy13_seq got n=%0d log=%h exp n=5 5,2,2,2,2", nlog - base, pack_log(base, 5)); end
    checks++; if (tube_levels !== 12'h048) begin errors++; $display("FAIL greedy13_tubes got=%h exp=048", tube_levels); end
  endtask

  task automatic test_shortfall;
    int base;
    bit ok;
    logic [7:0] sf;
    base = nlog;
    do_start(8'd16);
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd0) begin errors++; $display("FAIL drain21 ok=%b sf=%0d exp ok=1 sf=0", ok, sf); end
    checks++; if (nlog - base != 12 || pack_log(base, 12) !== {12'b0, {8{3'b001}}, {4{3'b010}}})
      begin errors++; $display("FAIL drain21_seq got n=%0d log=%h exp n=12", nlog - base, pack_log(base, 12)); end
    checks++; if (tube_levels !== 12'h000) begin errors++; $display("FAIL drain21_tubes got=%h exp=000", tube_levels); end
    pulse_coin(8'd5);
    base = nlog;
    do_start(8'd9);
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd4) begin errors++; $display("FAIL short9 ok=%b sf=%0d exp ok=1 sf=4", ok, sf); end
    checks++; if (nlog - base != 1 || pack_log(base, 1) !== {45'b0, 3'b100})
      begin errors++; $display("FAIL short9_seq got n=%0d log=%h exp n=1 5", nlog - base, pack_log(base, 1)); end
    repeat (5) @(negedge clk);
    checks++; if (shortfall !== 8'd4 || tube_levels !== 12'h000)
      begin errors++; $display("FAIL short9_hold sf=%0d tubes=%h exp sf=4 tubes=000", shortfall, tube_levels); end
    base = nlog;
    do_start(8'd3);
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd3 || nlog != base) begin errors++; $display("FAIL empty3 ok=%b sf=%0d n=%0d exp ok=1 sf=3 n=0", ok, sf, nlog - base); end
    do_start(8'd0);
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd0 || nlog != base) begin errors++; $display("FAIL zero ok=%b sf=%0d n=%0d exp ok=1 sf=0 n=0", ok, sf, nlog - base); end
  endtask

  task automatic test_restock;
    @(negedge clk);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    checks++; if (tube_levels !== 12'hfff) begin errors++; $display("FAIL restock got=%h exp=fff", tube_levels); end
    pulse_coin(8'd5);
    checks++; if (tube_levels !== 12'hfff) begin errors++; $display("FAIL saturate got=%h exp=fff", tube_levels); end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    logic [2:0] r;
    logic [7:0] sf;
    bit stray;
    auto_ack = 1'b0;
    do_start(8'd8);
    wait_req(ok, r);
    checks++; if (!ok || r !== 3'b100) begin errors++; $display("FAIL busy_req1 got=%b exp=100", r); end
    start = 1'b1;
    amount = 8'd3;
    @(negedge clk);
    start = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    checks++; if (eject_req !== 3'b000 || tube_levels !== 12'hefF)
      begin errors++; $display("FAIL busy_ack1 req=%b tubes=%h exp req=000 tubes=eff", eject_req, tube_levels); end
    wait_req(ok, r);
    checks++; if (!ok || r !== 3'b010) begin errors++; $display("FAIL busy_req2 got=%b exp=010", r); end
    man_ack = 1'b1;
    coin_pulse = 1'b1;
    coin_value = 8'd2;
    @(negedge clk);
    man_ack = 1'b0;
    coin_pulse = 1'b0;
    checks++; if (tube_levels !== 12'heff) begin errors++; $display("FAIL same_cycle_2 got=%h exp=eff", tube_levels); end
    wait_req(ok, r);
    checks++; if (!ok || r !== 3'b001) begin errors++; $display("FAIL busy_req3 got=%b exp=001", r); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd0 || tube_levels !== 12'hefe)
      begin errors++; $display("FAIL busy_done ok=%b sf=%0d tubes=%h exp ok=1 sf=0 tubes=efe", ok, sf, tube_levels); end
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy || eject_req != 3'b000) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL busy_ignored got=activity exp=idle"); end
    auto_ack = 1'b1;
  endtask

`ifdef CHANGE_DISP_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    logic [2:0] r;
    logic [7:0] sf;
    int n;
    int base;
    auto_ack = 1'b0;
    do_start(8'd5);
    wait_req(ok, r);
    checks++; if (!ok || r !== 3'b100) begin errors++; $display("FAIL to_req got=%b exp=100", r); end
    n = 0;
    while (n < ATO + 10 && !fault) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != ATO || fault !== 1'b1) begin errors++; $display("FAIL to_latency got=%0d fault=%b exp=%0d fault=1", n, fault, ATO); end
    checks++; if (tube_levels[11:8] !== 4'd0 || eject_req !== 3'b000)
      begin errors++; $display("FAIL to_clear count5=%0d req=%b exp 0 000", tube_levels[11:8], eject_req); end
    base = nlog;
    auto_ack = 1'b1;
    wait_done(ok, sf);
    checks++; if (!ok || sf !== 8'd0 || fault !== 1'b1) begin errors++; $display("FAIL to_done ok=%b sf=%0d fault=%b exp 1 0 1", ok, sf, fault); end
    checks++; if (nlog - base != 3 || pack_log(base, 3) !== {39'b0, 3'b001, 3'b010, 3'b010})
      begin errors++; $display("FAIL to_seq got n=%0d log=%h exp n=3 2,2,1", nlog - base, pack_log(base, 3)); end
  endtask
`endif

  task automatic test_reset_midop;
    bit ok;
    logic [2:0] r;
    bit saw_done;
    @(negedge clk);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    auto_ack = 1'b0;
    do_start(8'd5);
    wait_req(ok, r);
    checks++; if (!ok || r !== 3'b100) begin errors++; $display("FAIL mid_req got=%b exp=100", r); end
`ifndef CHANGE_DISP_TIMEOUT_EN
    repeat (3 * ATO) @(negedge clk);
    checks++; if (eject_req !== 3'b100 || fault !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL no_timeout req=%b fault=%b busy=%b exp 100 0 1", eject_req, fault, busy); end
`endif
    #2 rst = 1'b0;
    #1;
    checks++; if (eject_req !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || shortfall !== 8'd0 || fault !== 1'b0)
      begin errors++; $display("FAIL mid_reset_out req=%b busy=%b done=%b sf=%0d fault=%b exp all 0", eject_req, busy, done, shortfall, fault); end
    checks++; if (tube_levels !== 12'h888) begin errors++; $display("FAIL mid_reset_tubes got=%h exp=888", tube_levels); end
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (2 * GAP + 10) begin
      @(negedge clk);
      if (done || busy || eject_req != 3'b000) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL mid_reset_quiet got=activity exp=idle"); end
    auto_ack = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    amount = 8'd0;
    coin_pulse = 1'b0;
    coin_value = 8'd0;
    restock = 1'b0;
    man_ack = 1'b0;
    auto_ack = 1'b1;
    test_reset;
    test_basic;
    test_deposit;
    test_greedy;
    test_shortfall;
    test_restock;
    test_busy_ignore;
`ifdef CHANGE_DISP_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
